// File: rtl/pipe_stage_buf_pkg.sv
// rtl/pipe_stage_buf_pkg.sv - shared pipeline stage types, constants and helpers
package pipe_stage_buf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int PC_W_DEF   = 32;
    localparam int A_W_DEF    = 5;
    localparam int TNEW_W_DEF = 2;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [A_W_DEF-1:0]    a3;
        logic                  we;
        logic [TNEW_W_DEF-1:0] tnew;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

    // Tnew counts down by one per stage and must never wrap below zero
    function automatic int unsigned tnew_sat_dec(input int unsigned t);
        return (t == 32'd0) ? 32'd0 : t - 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - handshake, payload and forwarding signals of the stage buffer
interface pipe_stage_buf_if #(
    parameter int DATA_W = pipe_stage_buf_pkg::DATA_W_DEF,
    parameter int PC_W   = pipe_stage_buf_pkg::PC_W_DEF,
    parameter int A_W    = pipe_stage_buf_pkg::A_W_DEF,
    parameter int TNEW_W = pipe_stage_buf_pkg::TNEW_W_DEF
) ();
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [A_W-1:0]    in_a3;
    logic              in_we;
    logic [TNEW_W-1:0] in_tnew;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [A_W-1:0]    out_a3;
    logic              out_we;
    logic [TNEW_W-1:0] out_tnew;
    logic [DATA_W-1:0] out_data;
    logic              fwd_valid;
    logic [A_W-1:0]    fwd_a3;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output flush, in_valid, in_pc, in_a3, in_we, in_tnew, in_data, out_ready,
        input  in_ready, out_valid, out_pc, out_a3, out_we, out_tnew, out_data,
               fwd_valid, fwd_a3, fwd_data
    );

    modport slave (
        input  flush, in_valid, in_pc, in_a3, in_we, in_tnew, in_data, out_ready,
        output in_ready, out_valid, out_pc, out_a3, out_we, out_tnew, out_data,
               fwd_valid, fwd_a3, fwd_data
    );
endinterface

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one held pipeline entry with valid bit, load enable and clear
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         valid_d,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // clear drops the valid bit only; the payload keeps its last value
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            valid <= clear ? 1'b0 : valid_d;
            if (load && !clear) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - two-entry elastic pipeline stage with writeback tag and forwarding port
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int A_W    = A_W_DEF,
    parameter int TNEW_W = TNEW_W_DEF
) (
    input logic             clk,
    input logic             reset,
    pipe_stage_buf_if.slave bus
);

    localparam int ENTRY_W = PC_W + A_W + 1 + TNEW_W + DATA_W;

    logic               main_valid, skid_valid;
    logic               main_valid_d, skid_valid_d;
    logic               main_load, skid_load;
    logic               accept, pop;
    logic               cap_we;
    logic [TNEW_W-1:0]  cap_tnew;
    logic [ENTRY_W-1:0] cap, main_d, main_q, skid_q;

    logic [PC_W-1:0]    head_pc;
    logic [A_W-1:0]     head_a3;
    logic               head_we;
    logic [TNEW_W-1:0]  head_tnew;
    logic [DATA_W-1:0]  head_data;

    always_comb begin
        cap_tnew = TNEW_W'(tnew_sat_dec(32'(bus.in_tnew)));
        cap_we   = bus.in_we && (bus.in_a3 != A_W'(REG_ZERO));
        cap      = {bus.in_pc, bus.in_a3, cap_we, cap_tnew, bus.in_data};
    end

    // readiness depends only on the skid slot, so out_ready never reaches in_ready
    assign accept = bus.in_valid && !skid_valid;
    assign pop    = main_valid && bus.out_ready;

    always_comb begin
        main_valid_d = accept | skid_valid | (main_valid & ~pop);
        main_load    = (~main_valid & accept) | (pop & (skid_valid | accept));
        main_d       = skid_valid ? skid_q : cap;
        skid_valid_d = skid_valid ? ~pop : (main_valid & accept & ~pop);
        skid_load    = main_valid & accept & ~pop;
    end

    pipe_entry_reg #(.W(ENTRY_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.flush),
        .load    (main_load),
        .valid_d (main_valid_d),
        .d       (main_d),
        .valid   (main_valid),
        .q       (main_q)
    );

    pipe_entry_reg #(.W(ENTRY_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.flush),
        .load    (skid_load),
        .valid_d (skid_valid_d),
        .d       (cap),
        .valid   (skid_valid),
        .q       (skid_q)
    );

    assign {head_pc, head_a3, head_we, head_tnew, head_data} = main_q;

    assign bus.in_ready  = !skid_valid;
    assign bus.out_valid = main_valid;
    assign bus.out_pc    = head_pc;
    assign bus.out_a3    = head_a3;
    assign bus.out_we    = head_we;
    assign bus.out_tnew  = head_tnew;
    assign bus.out_data  = head_data;
    assign bus.fwd_valid = main_valid && head_we && (head_tnew == '0);
    assign bus.fwd_a3    = head_a3;
    assign bus.fwd_data  = head_data;

endmodule
